rw_monitor: RTL

- Downstream consumer of the read/write/ready strobe stage.
  - That stage registers `read <= !ctrl`, `write <= ctrl` and `ready <= write`.
  - All three come out of registers clocked by the same clock.
- rw_monitor tracks the write→ready handshake and counts reads and writes.
- Flags protocol violations as sticky errors.
- Buffers a timestamped event log in a small FIFO for a host to drain.

---
 rtl/rw_pkg.sv | 34 +++
 rtl/rw_monitor_if.sv | 30 +++
 rtl/rw_log_fifo.sv | 50 +++++
 rtl/rw_monitor.sv | 119 +++++++++++
 4 files changed

// File: rtl/rw_pkg.sv
// Shared types for the read/write monitor: log opcodes, FSM states and the
// log entry layout.
package rw_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_ERR   = 2'd3
  } op_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WR_PEND = 1'b1
  } state_e;

  // Default timestamp width. Modules whose width is parameterised build the
  // same {op, ts} layout locally at their own width.
  localparam int TS_W_DEF = 8;

  typedef struct packed {
    op_e                 op;
    logic [TS_W_DEF-1:0] ts;
  } log_entry_t;

  // One log push per cycle: an error outranks a write, which outranks a read.
  function automatic op_e push_op(input logic err, input logic wr, input logic rd);
    if (err)     return OP_ERR;
    else if (wr) return OP_WRITE;
    else if (rd) return OP_READ;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/rw_monitor_if.sv
// Bus between the strobe stage / log consumer and the monitor.
interface rw_monitor_if import rw_pkg::*; #(
  parameter int CNT_W = 8
) ();
  logic             read;
  logic             write;
  logic             ready;
  logic             log_pop;
  logic             log_valid;
  op_e              log_op;
  logic [CNT_W-1:0] log_ts;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
  logic             err_rw;
  logic             err_ready;
  logic             log_ovf;
  logic             busy;

  modport master (
    output read, write, ready, log_pop,
    input  log_valid, log_op, log_ts, rd_count, wr_count,
           err_rw, err_ready, log_ovf, busy
  );

  modport slave (
    input  read, write, ready, log_pop,
    output log_valid, log_op, log_ts, rd_count, wr_count,
           err_rw, err_ready, log_ovf, busy
  );
endinterface

// File: rtl/rw_log_fifo.sv
// Small first-word-fall-through event log. Pointers carry one extra wrap bit
// so full and empty are told apart by the MSB compare alone.
module rw_log_fifo import rw_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = log_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full,
  output logic   ovf
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Pop only when something is there; a push into a full FIFO only lands
  // when the same-cycle pop frees a slot.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer and overflow-flag update.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push)         wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)          rd_ptr <= rd_ptr + 1'b1;
      if (push & ~do_push) ovf    <= 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/rw_monitor.sv
// Watches the read/write/ready strobes: checks the write->ready handshake,
// counts reads and writes, flags violations and logs timestamped events.
module rw_monitor import rw_pkg::*; #(
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  rw_monitor_if.slave  bus
);
  typedef struct packed {
    op_e              op;
    logic [CNT_W-1:0] ts;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic             busy_q;
  logic             err_rw_q, err_ready_q;
  logic [CNT_W-1:0] ts, rd_cnt, wr_cnt;

  logic             rw_conflict, rd_ev, wr_ev, miss_ready;
  op_e              push_op_c;
  logic             push;
  entry_t           push_data, head;
  logic             fifo_empty, fifo_full, fifo_ovf;

  // Classify this cycle's strobes and pick the single log push.
  always_comb begin
    rw_conflict = bus.read & bus.write;
    rd_ev       = bus.read & ~bus.write;
    wr_ev       = bus.write & ~bus.read;
    miss_ready  = (state == S_WR_PEND) & ~bus.ready;
    push_op_c   = push_op(miss_ready | rw_conflict, wr_ev, rd_ev);
    push        = (push_op_c != OP_NONE);
    push_data   = '{op: push_op_c, ts: ts};
  end

  // Handshake FSM: a write must be acknowledged by ready on the very next
  // cycle. A new write in the ack cycle re-arms the check; ready in IDLE is
  // ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy_q      <= 1'b0;
      err_ready_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_ev) begin
            state  <= S_WR_PEND;
            busy_q <= 1'b1;
          end
        end
        S_WR_PEND: begin
          if (!bus.ready) err_ready_q <= 1'b1;
          state  <= wr_ev ? S_WR_PEND : S_IDLE;
          busy_q <= wr_ev;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating event counters and the sticky conflict flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      err_rw_q <= 1'b0;
    end else begin
      if (rd_ev && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr_ev && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + CNT_W'(1);
      if (rw_conflict)                err_rw_q <= 1'b1;
    end
  end

  // Free-running timestamp; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + CNT_W'(1);
  end

  rw_log_fifo #(
    .DEPTH   (LOG_DEPTH),
    .entry_t (entry_t)
  ) u_log (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.log_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .ovf       (fifo_ovf)
  );

  // Drive the bus outputs from registered state.
  always_comb begin
    bus.log_valid = ~fifo_empty;
    bus.log_op    = head.op;
    bus.log_ts    = head.ts;
    bus.rd_count  = rd_cnt;
    bus.wr_count  = wr_cnt;
    bus.err_rw    = err_rw_q;
    bus.err_ready = err_ready_q;
    bus.log_ovf   = fifo_ovf;
    bus.busy      = busy_q;
  end

  // Fullness is consumed inside the FIFO; keep the port for observability.
  logic unused_full;
  assign unused_full = fifo_full;
endmodule
